gf_pipelined_adder: RTL and testbench
=====================================

GF_PIPELINED_ADDER -- requirements
Module: gf_pipelined_adder

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 Parameter WIDTH, default 8, is the operand width in bits; legal range 2..32.
REQ-003 Port clk, input, 1 bit: the single clock, sampled on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: operands on this cycle form a transaction.
REQ-006 Port a, input, WIDTH bits: operand A, unsigned or two's complement.
REQ-007 Port b, input, WIDTH bits: operand B.
REQ-008 Port carry_in, input, 1 bit: carry into bit 0, used in add mode only.
REQ-009 Port sub, input, 1 bit: 0 selects A+B+carry_in; 1 selects A-B.
REQ-010 Port out_valid, output, 1 bit: the result on this cycle is valid.
REQ-011 Port sum, output, WIDTH bits: result bits.
REQ-012 Port carry_out, output, 1 bit: carry out of the MSB (add); not-borrow (sub).
REQ-013 Port overflow, output, 1 bit: signed overflow of the result.

Function
REQ-014 Every transaction SHALL be accepted whenever in_valid=1; there is no backpressure; throughput is one transaction per clock.
REQ-015 Latency SHALL be exactly WIDTH+1 cycles from the in_valid sample edge to out_valid=1, for every WIDTH.
REQ-016 The datapath is a carry-ripple pipeline:
  - stage k (0..WIDTH-1) computes bit k from the registered carry of stage k-1;
  - operand bit k is delayed k cycles by a DFF skew chain;
  - sum bit k is delayed WIDTH-1-k cycles by a deskew chain;
  - one final output register follows.
REQ-017 Sub mode SHALL compute A + ~B + 1: B bits are inverted at input and carry into bit 0 is forced to 1, ignoring carry_in.
REQ-018 The sub bit SHALL travel with its transaction, so mixed add/sub streams on consecutive cycles produce independent, correct results.
REQ-019 Result widths:
  - sum = (A op B) mod 2^WIDTH;
  - carry_out = carry out of bit WIDTH-1;
  - overflow = carry into MSB XOR carry out of MSB.
REQ-020 A valid bit SHALL travel alongside the data. A cycle with in_valid=0 is a bubble, and WIDTH+1 cycles later out_valid=0 with sum, carry_out and overflow forced to 0.
REQ-021 Back-to-back transactions and arbitrary bubble patterns SHALL NOT interfere; each stage holds state only for its own transaction.
REQ-022 Carry wrap: all-ones + 1 gives sum=0 and carry_out=1; no state is retained between transactions.

Reset
REQ-023 rst_n=0 SHALL asynchronously clear every pipeline, skew and valid register, and drive out_valid, sum, carry_out and overflow to 0.
REQ-024 Reset mid-operation SHALL discard all in-flight transactions, with no partial result emitted.
REQ-025 After rst_n deasserts, out_valid SHALL stay 0 until WIDTH+1 cycles after the first accepted in_valid.

Structure
REQ-026 Shared package gf_pkg SHALL hold the WIDTH default, the latency function LAT(W)=W+1, and the stage record typedef {valid, sub, carry}.
REQ-027 Sub-module gf_fa_stage, one pipelined full-adder bit cell, SHALL be instantiated WIDTH times via generate.
REQ-028 The skew and deskew chains are parametrised DFF arrays inside the top level; there are no latches and no combinational path from any input to any output.

Verification (WIDTH=8, latency 9)
REQ-029 Scenario 1: a=0x3C, b=0x05, carry_in=1, sub=0, one valid cycle -> 9 cycles later out_valid=1, sum=0x42, carry_out=0, overflow=0.
REQ-030 Scenario 2: a=0xFF, b=0x01, sub=0 -> sum=0x00, carry_out=1, overflow=0; then a=0x7F, b=0x01 -> sum=0x80, overflow=1.
REQ-031 Scenario 3: a=0x10, b=0x20, sub=1 -> sum=0xF0, carry_out=0; then a=0x80, b=0x01, sub=1 -> sum=0x7F, overflow=1.
REQ-032 Scenario 4: 20 back-to-back random transactions, alternating sub, with bubbles on cycles 5 and 11 -> results in order; out_valid=0 and outputs 0 exactly at the bubble slots.
REQ-033 Scenario 5: assert rst_n=0 for 1 cycle while 4 transactions are in flight -> outputs 0 immediately, none of the 4 ever appear, and the next transaction emerges 9 cycles after its accept.
REQ-034 Scenario 6: repeat scenarios 1-4 with WIDTH=2 and WIDTH=16 -> latency 3 and 17 respectively, with results matching a reference model.

Source files
------------

// File: rtl/gf_pkg.sv
// Shared definitions for the bit-serial carry-ripple pipelined adder.
package gf_pkg;

  localparam int GF_WIDTH_DEFAULT = 8;

  // Cycles from the in_valid sample edge to out_valid for operand width w.
  function automatic int lat(input int w);
    return w + 1;
  endfunction

  // Control that rides alongside one transaction through the bit stages.
  typedef struct packed {
    logic valid;
    logic sub;
    logic carry;
  } stage_t;

endpackage

// File: rtl/gf_fa_stage.sv
// One pipelined full-adder bit cell: adds one operand bit pair to the carry
// handed over by the previous stage and registers sum, carry and valid.
module gf_fa_stage
  import gf_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t in_rec,
  input  logic   a_bit,
  input  logic   b_bit,
  output logic   valid_q,
  output logic   carry_q,
  output logic   sum_q
);

  logic b_eff;
  logic valid_d;
  logic carry_d;
  logic sum_d;

  // B is inverted here using the sub bit that travels with this transaction,
  // so a mixed add/sub stream never uses a neighbour's mode; bubbles yield 0.
  always_comb begin
    b_eff   = b_bit ^ in_rec.sub;
    valid_d = in_rec.valid;
    sum_d   = 1'b0;
    carry_d = 1'b0;
    if (in_rec.valid) begin
      sum_d   = a_bit ^ b_eff ^ in_rec.carry;
      carry_d = (a_bit & b_eff) | (in_rec.carry & (a_bit ^ b_eff));
    end
  end

  // Stage register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: rtl/gf_pipelined_adder.sv
// Carry-ripple pipelined adder/subtractor: one bit per stage, operands skewed
// in and sum bits deskewed out, latency WIDTH+1, one transaction per clock.
module gf_pipelined_adder
  import gf_pkg::*;
#(
  parameter int WIDTH = GF_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  logic [WIDTH-1:0] a_in_q, a_in_d;
  logic [WIDTH-1:0] b_in_q, b_in_d;
  logic             valid_in_q, valid_in_d;
  logic             sub_in_q, sub_in_d;
  logic             carry_in_q, carry_in_d;

  logic             sub_skew_q [1:WIDTH-1];
  logic             sub_skew_d [1:WIDTH-1];

  stage_t           stage_rec [WIDTH];
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] stage_valid, stage_carry, stage_sum;
  logic [WIDTH-1:0] sum_aligned;

  logic             msb_cin_q, msb_cin_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  // Capture the transaction; subtract forces the carry into bit 0 to 1.
  always_comb begin
    a_in_d     = a;
    b_in_d     = b;
    valid_in_d = in_valid;
    sub_in_d   = sub;
    carry_in_d = sub | carry_in;
  end

  // Input capture register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_in_q     <= '0;
      b_in_q     <= '0;
      valid_in_q <= 1'b0;
      sub_in_q   <= 1'b0;
      carry_in_q <= 1'b0;
    end else begin
      a_in_q     <= a_in_d;
      b_in_q     <= b_in_d;
      valid_in_q <= valid_in_d;
      sub_in_q   <= sub_in_d;
      carry_in_q <= carry_in_d;
    end
  end

  // Mode bit skew: stage k sees the sub bit delayed k cycles.
  always_comb begin
    sub_skew_d[1] = sub_in_q;
    for (int j = 2; j < WIDTH; j++) begin
      sub_skew_d[j] = sub_skew_q[j-1];
    end
  end

  // Mode skew register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 1; j < WIDTH; j++) begin
        sub_skew_q[j] <= 1'b0;
      end
    end else begin
      sub_skew_q <= sub_skew_d;
    end
  end

  // Each stage's control record: valid and carry come from the previous cell.
  always_comb begin
    stage_rec[0].valid = valid_in_q;
    stage_rec[0].sub   = sub_in_q;
    stage_rec[0].carry = carry_in_q;
    for (int k = 1; k < WIDTH; k++) begin
      stage_rec[k].valid = stage_valid[k-1];
      stage_rec[k].sub   = sub_skew_q[k];
      stage_rec[k].carry = stage_carry[k-1];
    end
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    if (k == 0) begin : g_no_skew
      assign op_a[k] = a_in_q[k];
      assign op_b[k] = b_in_q[k];
    end else begin : g_skew
      logic skew_a_q [0:k-1];
      logic skew_a_d [0:k-1];
      logic skew_b_q [0:k-1];
      logic skew_b_d [0:k-1];

      // Delay operand bit k by k cycles so it meets its ripple carry.
      always_comb begin
        skew_a_d[0] = a_in_q[k];
        skew_b_d[0] = b_in_q[k];
        for (int j = 1; j < k; j++) begin
          skew_a_d[j] = skew_a_q[j-1];
          skew_b_d[j] = skew_b_q[j-1];
        end
      end

      // Operand skew register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < k; j++) begin
            skew_a_q[j] <= 1'b0;
            skew_b_q[j] <= 1'b0;
          end
        end else begin
          skew_a_q <= skew_a_d;
          skew_b_q <= skew_b_d;
        end
      end

      assign op_a[k] = skew_a_q[k-1];
      assign op_b[k] = skew_b_q[k-1];
    end

    gf_fa_stage u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_rec  (stage_rec[k]),
      .a_bit   (op_a[k]),
      .b_bit   (op_b[k]),
      .valid_q (stage_valid[k]),
      .carry_q (stage_carry[k]),
      .sum_q   (stage_sum[k])
    );

    if (k == WIDTH - 1) begin : g_no_deskew
      assign sum_aligned[k] = stage_sum[k];
    end else begin : g_deskew
      localparam int DLEN = WIDTH - 1 - k;
      logic deskew_q [0:DLEN-1];
      logic deskew_d [0:DLEN-1];

      // Delay sum bit k so all bits of a transaction line up at the MSB stage.
      always_comb begin
        deskew_d[0] = stage_sum[k];
        for (int j = 1; j < DLEN; j++) begin
          deskew_d[j] = deskew_q[j-1];
        end
      end

      // Sum deskew register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < DLEN; j++) begin
            deskew_q[j] <= 1'b0;
          end
        end else begin
          deskew_q <= deskew_d;
        end
      end

      assign sum_aligned[k] = deskew_q[DLEN-1];
    end
  end

  // Keep the carry into the MSB alongside the MSB stage for overflow.
  always_comb begin
    msb_cin_d = stage_carry[WIDTH-2];
  end

  // MSB carry-in register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb_cin_q <= 1'b0;
    end else begin
      msb_cin_q <= msb_cin_d;
    end
  end

  // Final result; bubbles present all-zero outputs.
  always_comb begin
    out_valid_d = stage_valid[WIDTH-1];
    sum_d       = '0;
    carry_out_d = 1'b0;
    overflow_d  = 1'b0;
    if (stage_valid[WIDTH-1]) begin
      sum_d       = sum_aligned;
      carry_out_d = stage_carry[WIDTH-1];
      overflow_d  = msb_cin_q ^ stage_carry[WIDTH-1];
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_gf_pipelined_adder.sv
// Self-checking bench: three widths (8, 2, 16) driven in lockstep; every cycle
// each output is compared with the expectation recorded LAT cycles earlier.
module tb_gf_pipelined_adder;
  import gf_pkg::*;

  localparam int LAT8    = lat(8);
  localparam int LAT2    = lat(2);
  localparam int LAT16   = lat(16);
  localparam int MAXSLOT = 512;

  typedef struct {
    logic        valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        hand;
    logic [7:0]  sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        carry_in;
  logic        sub;
  logic [7:0]  a8, b8, s8;
  logic [1:0]  a2, b2, s2;
  logic [15:0] a16, b16, s16;
  logic        ov8, co8, of8;
  logic        ov2, co2, of2;
  logic        ov16, co16, of16;

  logic [34:0] exp8  [MAXSLOT];
  logic [34:0] exp2  [MAXSLOT];
  logic [34:0] exp16 [MAXSLOT];
  int          cur;
  int          checks;
  int          failures;
  int          n_txn;
  vec_t        tbl [$];

  always #5 clk = ~clk;

  gf_pipelined_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8),
    .carry_in(carry_in), .sub(sub), .out_valid(ov8), .sum(s8),
    .carry_out(co8), .overflow(of8)
  );

  gf_pipelined_adder #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a2), .b(b2),
    .carry_in(carry_in), .sub(sub), .out_valid(ov2), .sum(s2),
    .carry_out(co2), .overflow(of2)
  );

  gf_pipelined_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a16), .b(b16),
    .carry_in(carry_in), .sub(sub), .out_valid(ov16), .sum(s16),
    .carry_out(co16), .overflow(of16)
  );

  // Arithmetic reference: {valid, overflow, carry_out, sum[31:0]}.
  function automatic logic [34:0] refModel(input int w, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin,
                                           input logic sb);
    logic [32:0] m, lm, aa, bb, full, low;
    logic        c0, cout, cmsb;
    m    = (33'd1 << w) - 33'd1;
    lm   = (33'd1 << (w - 1)) - 33'd1;
    aa   = {17'd0, a} & m;
    bb   = sb ? (~{17'd0, b}) & m : {17'd0, b} & m;
    c0   = sb ? 1'b1 : cin;
    full = aa + bb + {32'd0, c0};
    low  = (aa & lm) + (bb & lm) + {32'd0, c0};
    cout = full[w];
    cmsb = low[w-1];
    return {1'b1, cout ^ cmsb, cout, full[31:0] & m[31:0]};
  endfunction

  function automatic vec_t mkVec(input logic v, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sb, input logic hand,
                                 input logic [7:0] s, input logic co, input logic of);
    vec_t r;
    r.valid = v; r.a = a; r.b = b; r.cin = cin; r.sub = sb;
    r.hand = hand; r.sum = s; r.cout = co; r.ovf = of;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int slot,
                             input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s slot=%0d got v=%b ovf=%b co=%b sum=%h expected v=%b ovf=%b co=%b sum=%h",
               name, slot, act[34], act[33], act[32], act[31:0],
               exp[34], exp[33], exp[32], exp[31:0]);
    end
  endtask

  function automatic logic [34:0] expAt(input int which, input int slot);
    if (slot < 0) return '0;
    case (which)
      8:       return exp8[slot];
      2:       return exp2[slot];
      default: return exp16[slot];
    endcase
  endfunction

  // Drive one slot into all DUTs, record expectations, clock, compare outputs.
  task automatic applyStimulus(input vec_t v);
    in_valid = v.valid;
    carry_in = v.cin;
    sub      = v.sub;
    a8  = v.a[7:0];  b8  = v.b[7:0];
    a2  = v.a[1:0];  b2  = v.b[1:0];
    a16 = v.a;       b16 = v.b;
    if (!v.valid) begin
      exp8[cur]  = '0;
      exp2[cur]  = '0;
      exp16[cur] = '0;
    end else begin
      exp8[cur]  = v.hand ? {1'b1, v.ovf, v.cout, 24'd0, v.sum}
                          : refModel(8, {8'd0, v.a[7:0]}, {8'd0, v.b[7:0]}, v.cin, v.sub);
      exp2[cur]  = refModel(2, v.a, v.b, v.cin, v.sub);
      exp16[cur] = refModel(16, v.a, v.b, v.cin, v.sub);
    end
    tick();
    checkOutput("w8",  cur - LAT8,  {ov8, of8, co8, 24'd0, s8},    expAt(8, cur - LAT8));
    checkOutput("w2",  cur - LAT2,  {ov2, of2, co2, 30'd0, s2},    expAt(2, cur - LAT2));
    checkOutput("w16", cur - LAT16, {ov16, of16, co16, 16'd0, s16}, expAt(16, cur - LAT16));
    cur++;
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(mkVec(1'b0, 16'hA5C3, 16'h3C5A, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0));
    end
  endtask

  initial begin
    checks = 0; failures = 0; cur = 0; n_txn = 0;
    for (int i = 0; i < MAXSLOT; i++) begin
      exp8[i] = '0; exp2[i] = '0; exp16[i] = '0;
    end
    rst_n = 1'b0; in_valid = 1'b0; carry_in = 1'b0; sub = 1'b0;
    a8 = '0; b8 = '0; a2 = '0; b2 = '0; a16 = '0; b16 = '0;

    // Reset state.
    tick();
    tick();
    checkOutput("rst_w8",  -1, {ov8, of8, co8, 24'd0, s8},      '0);
    checkOutput("rst_w2",  -1, {ov2, of2, co2, 30'd0, s2},      '0);
    checkOutput("rst_w16", -1, {ov16, of16, co16, 16'd0, s16}, '0);
    rst_n = 1'b1;

    // Hand-computed 8-bit vectors (scenarios 1-3 plus wrap/overflow corners).
    tbl.push_back(mkVec(1, 16'h3C, 16'h05, 1, 0, 1, 8'h42, 0, 0));
    tbl.push_back(mkVec(0, 16'h00, 16'h00, 0, 0, 1, 8'h00, 0, 0));
    tbl.push_back(mkVec(1, 16'hFF, 16'h01, 0, 0, 1, 8'h00, 1, 0));
    tbl.push_back(mkVec(1, 16'h7F, 16'h01, 0, 0, 1, 8'h80, 0, 1));
    tbl.push_back(mkVec(1, 16'h10, 16'h20, 0, 1, 1, 8'hF0, 0, 0));
    tbl.push_back(mkVec(1, 16'h80, 16'h01, 0, 1, 1, 8'h7F, 1, 1));
    tbl.push_back(mkVec(0, 16'hFF, 16'hFF, 1, 0, 1, 8'h00, 0, 0));
    tbl.push_back(mkVec(1, 16'h05, 16'h05, 0, 1, 1, 8'h00, 1, 0));
    tbl.push_back(mkVec(1, 16'h00, 16'h01, 1, 1, 1, 8'hFF, 0, 0));
    tbl.push_back(mkVec(1, 16'h40, 16'h40, 0, 0, 1, 8'h80, 0, 1));
    tbl.push_back(mkVec(1, 16'h80, 16'h80, 0, 0, 1, 8'h00, 1, 1));
    tbl.push_back(mkVec(1, 16'hFF, 16'hFF, 1, 0, 1, 8'hFF, 1, 0));
    tbl.push_back(mkVec(1, 16'hFF, 16'h00, 1, 0, 1, 8'h00, 1, 0));
    tbl.push_back(mkVec(1, 16'hFFFF, 16'h0001, 0, 0, 0, 8'h00, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
    end
    bubbles(LAT16);

    // Back-to-back random stream, alternating sub, bubbles on cycles 5 and 11.
    for (int i = 0; i < 22; i++) begin
      if (i == 5 || i == 11) begin
        applyStimulus(mkVec(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                            0, 8'h00, 0, 0));
      end else begin
        applyStimulus(mkVec(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'(n_txn % 2),
                            0, 8'h00, 0, 0));
        n_txn++;
      end
    end
    bubbles(LAT16);

    // Mid-flight reset: one result emerging, four more in flight.
    applyStimulus(mkVec(1, 16'h1234, 16'h0F0F, 1, 0, 0, 8'h00, 0, 0));
    bubbles(4);
    applyStimulus(mkVec(1, 16'h1111, 16'h2222, 0, 0, 0, 8'h00, 0, 0));
    applyStimulus(mkVec(1, 16'h5555, 16'h1111, 0, 1, 0, 8'h00, 0, 0));
    applyStimulus(mkVec(1, 16'h7F7F, 16'h0101, 1, 0, 0, 8'h00, 0, 0));
    applyStimulus(mkVec(1, 16'h8080, 16'h0001, 0, 1, 0, 8'h00, 0, 0));
    bubbles(1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_w8",  -1, {ov8, of8, co8, 24'd0, s8},      '0);
    checkOutput("midrst_w2",  -1, {ov2, of2, co2, 30'd0, s2},      '0);
    checkOutput("midrst_w16", -1, {ov16, of16, co16, 16'd0, s16}, '0);
    for (int s = 0; s < cur; s++) begin
      exp8[s] = '0; exp2[s] = '0; exp16[s] = '0;
    end
    bubbles(1);
    rst_n = 1'b1;
    applyStimulus(mkVec(1, 16'h00C3, 16'h003C, 1, 0, 0, 8'h00, 0, 0));
    bubbles(LAT16 + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
